// File: rtl/sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper.
// Golden default models Y = ~A & D with A as the vector MSB.
package sweeper_pkg;

   localparam int N_VEC = 16;
   localparam int IDX_W = 4;
   localparam int CNT_W = 5;

   localparam logic [N_VEC-1:0] GOLDEN_DEF = 16'h00AA;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      DONE
   } state_t;

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Loadable down-counter; o_tc is high while the count sits at zero.
// The FSM loads SETTLE_CYCLES-1 on SETTLE entry.
module settle_timer #(
   parameter int W = 4
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_tc
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all 16 input vectors, samples Y, builds and grades the truth table.
// Optional STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module truth_table_sweeper
   import sweeper_pkg::*;
#(
   parameter int               SETTLE_CYCLES = 2,
   parameter logic [N_VEC-1:0] EXPECTED      = GOLDEN_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   output logic [IDX_W-1:0] o_dut_in,
   input  logic             i_dut_y,
   output logic             o_busy,
   output logic             o_done,
   output logic [N_VEC-1:0] o_table,
   output logic             o_pass,
   output logic [CNT_W-1:0] o_mismatch_cnt,
   output logic [IDX_W-1:0] o_first_fail_idx
);

   state_t           r_state;
   state_t           w_next;
   logic [IDX_W-1:0] r_idx;
   logic [N_VEC-1:0] r_table;
   logic             r_pass;
   logic [CNT_W-1:0] r_mis;
   logic [IDX_W-1:0] r_ffi;

   logic             w_tc;
   logic             w_load;
   logic             w_miss;
   logic             w_stop;
   logic             w_last;
   logic [CNT_W-1:0] w_mis_nx;

   settle_timer #(.W(IDX_W)) u_timer (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (w_load),
      .i_load_val (IDX_W'(SETTLE_CYCLES - 1)),
      .o_tc       (w_tc)
   );

   assign w_miss   = (i_dut_y != EXPECTED[r_idx]);
   assign w_mis_nx = r_mis + CNT_W'(w_miss);

`ifdef STOP_ON_FAIL_EN
   assign w_stop = w_miss;
`else
   assign w_stop = 1'b0;
`endif

   assign w_last = (r_idx == IDX_W'(N_VEC - 1)) || w_stop;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (i_start) w_next = SETTLE;
         SETTLE:  if (w_tc)    w_next = SAMPLE;
         SAMPLE:  w_next = w_last ? DONE : SETTLE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      o_busy = (r_state != IDLE);
      o_done = (r_state == DONE);
      w_load = (w_next == SETTLE) && (r_state != SETTLE);
   end

   // Results persist through IDLE and are cleared only on an accepted start.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_idx   <= '0;
         r_table <= '0;
         r_pass  <= 1'b0;
         r_mis   <= '0;
         r_ffi   <= '0;
      end else begin
         if (r_state == IDLE && i_start) begin
            r_idx   <= '0;
            r_table <= '0;
            r_pass  <= 1'b0;
            r_mis   <= '0;
            r_ffi   <= '0;
         end
         if (r_state == SAMPLE) begin
            r_table[r_idx] <= i_dut_y;
            r_mis          <= w_mis_nx;
            if (w_miss && r_mis == '0) r_ffi <= r_idx;
            if (w_last) r_pass <= (w_mis_nx == '0);
            else        r_idx  <= r_idx + IDX_W'(1);
         end
      end
   end

   assign o_dut_in         = r_idx;
   assign o_table          = r_table;
   assign o_pass           = r_pass;
   assign o_mismatch_cnt   = r_mis;
   assign o_first_fail_idx = r_ffi;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper; a second instance runs with
// SETTLE_CYCLES=1. Honours STOP_ON_FAIL_EN in its reference model.
module tb_truth_table_sweeper;

   logic        clk = 1'b0;
   logic        rst, start, start1;
   logic [3:0]  din, din1;
   logic        y, y1;
   logic        busy, done, pass, busy1, done1, pass1;
   logic [15:0] tab, tab1;
   logic [4:0]  mis, mis1;
   logic [3:0]  ffi, ffi1;
   logic [15:0] tt_cur = 16'h0;
   logic [15:0] gold;
   int          cyc = 0;
   int          ntot = 0;
   int          npass = 0;

   typedef struct {
      logic [15:0] tab;
      logic        pass;
      logic [4:0]  mis;
      logic [3:0]  ffi;
      int          dcyc;
   } exp_t;

   exp_t q[$];
   exp_t me;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign y  = tt_cur[din];
   assign y1 = gold[din1];

   truth_table_sweeper dut (
      .i_clk(clk), .i_rst(rst), .i_start(start),
      .o_dut_in(din), .i_dut_y(y), .o_busy(busy), .o_done(done),
      .o_table(tab), .o_pass(pass), .o_mismatch_cnt(mis),
      .o_first_fail_idx(ffi)
   );

   truth_table_sweeper #(.SETTLE_CYCLES(1)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_start(start1),
      .o_dut_in(din1), .i_dut_y(y1), .o_busy(busy1), .o_done(done1),
      .o_table(tab1), .o_pass(pass1), .o_mismatch_cnt(mis1),
      .o_first_fail_idx(ffi1)
   );

   function automatic logic [15:0] golden();
      logic [15:0] g;
      for (int i = 0; i < 16; i++) begin
         logic [3:0] v;
         v = 4'(i);
         g[i] = ~v[3] & v[0];
      end
      return g;
   endfunction

   // Expected result of sweeping a unit whose truth table is tt, started at c.
   function automatic exp_t model(input logic [15:0] tt, input int c);
      exp_t e;
      int   last;
      e.tab = '0; e.mis = '0; e.ffi = '0; last = 15;
      for (int i = 0; i < 16; i++) begin
         e.tab[i] = tt[i];
         if (tt[i] != gold[i]) begin
            if (e.mis == 0) e.ffi = 4'(i);
            e.mis = e.mis + 5'd1;
`ifdef STOP_ON_FAIL_EN
            last = i;
            break;
`endif
         end
      end
      e.pass = (e.mis == 0);
      e.dcyc = c + (last + 1) * 3 + 1;
      return e;
   endfunction

   task automatic chk(input string n, input logic [31:0] a,
                      input logic [31:0] e);
      ntot++;
      if (a === e) npass++;
      else $display("FAIL %s: got %0h expected %0h (cyc %0d)", n, a, e, cyc);
   endtask

   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (q.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            me = q.pop_front();
            chk("table", 32'(tab), 32'(me.tab));
            chk("pass", 32'(pass), 32'(me.pass));
            chk("mismatch_cnt", 32'(mis), 32'(me.mis));
            if (!me.pass) chk("first_fail_idx", 32'(ffi), 32'(me.ffi));
            chk("done_cycle", cyc, me.dcyc);
            chk("busy_at_done", 32'(busy), 1);
         end
      end
   end

   // Drives a one-cycle start; returns at the negedge of cycle 1.
   task automatic go(input logic [15:0] tt, output int c);
      @(negedge clk);
      tt_cur = tt;
      c = cyc;
      start = 1'b1;
      q.push_back(model(tt, c));
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         chk("timeout_waiting_done", 0, 1);
         q.delete();
      end
      @(negedge clk);
   endtask

   task automatic wait_to(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   initial begin
      int c, c2;
      gold   = golden();
      rst    = 1'b1;
      start  = 1'b0;
      start1 = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_outs", 32'({din, tab, pass, mis, ffi}), 0);
      chk("rst_outs1", 32'({din1, busy1, done1, tab1, pass1, mis1, ffi1}), 0);
      rst = 1'b0;

      // Correct unit: vector stepping, hold time, and busy window.
      go(gold, c);
      for (int k = 1; k <= 48; k++) begin
         if (k > 1) @(negedge clk);
         chk("dut_in_step", 32'(din), 32'((k - 1) / 3));
         chk("busy_sweep", 32'(busy), 1);
         chk("no_early_done", 32'(done), 0);
      end
      @(negedge clk);
      @(negedge clk);
      chk("busy_after", 32'(busy), 0);
      chk("done_pulse_width", 32'(done), 0);
      chk("pass_held", 32'(pass), 1);
      chk("dut_in_held", 32'(din), 15);

      // Output stuck at zero.
      go(16'h0000, c);
      wait_idle();

      // Extra starts while busy and during DONE are ignored.
      go(gold, c);
      wait_to(c + 10);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_to(c + 49);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_to(c + 110);
      chk("single_done", 32'(q.size()), 0);
      chk("no_restart", 32'(busy), 0);

      // Synchronous reset mid-sweep aborts without a done pulse.
      go(gold, c);
      wait_to(c + 20);
      rst = 1'b1;
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      chk("abort_outs", 32'({din, busy, done, tab, pass, mis, ffi}), 0);
      repeat (60) @(negedge clk);
      chk("abort_no_done", 32'(busy), 0);
      go(gold, c);
      wait_idle();

      // Back-to-back: start in the cycle after done.
      go(gold, c);
      wait_to(c + 49);
      go(16'hFFFF, c2);
      chk("cleared_table", 32'(tab), 0);
      chk("cleared_pass", 32'(pass), 0);
      chk("cleared_mis", 32'(mis), 0);
      chk("b2b_spacing", c2 - c, 50);
      wait_idle();

      // Random truth tables with random idle gaps.
      for (int r = 0; r < 8; r++) begin
         logic [15:0] tt;
         tt = 16'($urandom);
         if (r == 0) tt = ~gold;
         if (r == 1) tt = gold ^ 16'h8000;
         repeat ($urandom_range(0, 3)) @(negedge clk);
         go(tt, c);
         wait_idle();
      end

      // SETTLE_CYCLES=1 instance.
      @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      for (int k = 1; k <= 36; k++) begin
         if (k > 1) @(negedge clk);
         if (k <= 32) chk("s1_dut_in", 32'(din1), 32'((k - 1) / 2));
         chk("s1_done", 32'(done1), 32'(k == 33));
         if (k == 33) begin
            chk("s1_pass", 32'(pass1), 1);
            chk("s1_table", 32'(tab1), 32'(gold));
            chk("s1_mis", 32'(mis1), 0);
         end
      end
      chk("s1_idle", 32'(busy1), 0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Self-test sequencer for the 4-input combinational logic units in this lab codebase, such as circuit_a.
- On start, drives all 16 input vectors onto the unit under sweep in ascending order.
- Waits a programmable settle time per vector, then samples Y.
- Builds the 16-bit truth table, compares it bit-by-bit against a golden table, and reports pass/fail, mismatch count and first failing index.

Parameters:
SETTLE_CYCLES, 2, cycles each vector is held before sampling; legal range 1..15.
EXPECTED, 16'h00AA, golden truth table; bit i = required Y for input vector i, with A as the MSB of i (Y = ~A & D).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  begin a sweep; sampled only in IDLE.
dut_in  out  4  {A,B,C,D} driven to the unit under sweep.
dut_y  in  1  Y returned from the unit under sweep.
busy  out  1  high from the start-accept edge until the DONE state is left.
done  out  1  single-cycle pulse when results are valid.
table  out  16  captured truth table; bit i = sampled dut_y for vector i.
pass  out  1  1 when table == EXPECTED; valid from done, held until next start.
mismatch_cnt  out  5  number of differing bits, 0..16.
first_fail_idx  out  4  lowest index whose sample mismatched; meaningful only when pass=0.

Behaviour:
- Reset (synchronous): state=IDLE and idx=0. All outputs are 0: dut_in, busy, done, table, pass, mismatch_cnt, first_fail_idx.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - If start=1 at an edge: go to SETTLE, set idx=0, dut_in=0, busy=1.
  - On the same edge, clear table, pass, mismatch_cnt and first_fail_idx.
  - If start=0: hold all results.
- SETTLE:
  - dut_in=idx; settle counter counts 0..SETTLE_CYCLES-1.
  - On the terminal count, go to SAMPLE.
  - Vector hold time is SETTLE_CYCLES+1 cycles (includes the SAMPLE cycle).
- SAMPLE:
  - At the exit edge: table[idx] <= dut_y.
  - If dut_y != EXPECTED[idx]: mismatch_cnt increments. If this is the first mismatch of the sweep, first_fail_idx <= idx.
  - If idx==15: go to DONE. Otherwise idx increments and state returns to SETTLE with dut_in updated on the same edge.
  - No wrap past 15.
- DONE:
  - Lasts exactly 1 cycle; done=1 and pass=(mismatch_cnt==0) (computed including the final sample).
  - Then go to IDLE with busy=0.
  - dut_in holds its last value until the next start.
- Latency: done is asserted in cycle 16*(SETTLE_CYCLES+1)+1 after the start-accept edge; this is cycle 49 at the defaults.
- start while busy (SETTLE/SAMPLE/DONE) is ignored; there is no queuing.
- start in the cycle after done is accepted normally (back-to-back sweeps).
- rst mid-sweep: aborts immediately to the reset values; no done pulse; partial results are discarded.
- dut_y is used only at the SAMPLE exit edge; its value in other cycles is don't-care.

Optional Feature:
STOP_ON_FAIL_EN
- Defined: on the first mismatch in SAMPLE, go directly to DONE instead of advancing idx.
  - Bits of table above the failing index remain 0.
  - mismatch_cnt=1 and pass=0.
- Undefined: the full 16-vector sweep always runs and mismatch_cnt counts all differences.

Decomposition:
- Package sweeper_pkg holds:
  - state enum (IDLE, SETTLE, SAMPLE, DONE);
  - N_VEC=16, IDX_W=4, CNT_W=5;
  - default golden-table constant 16'h00AA.
- One sub-module: settle_timer.
  - Parameterised down-counter with load and terminal-count output, driven by the FSM on SETTLE entry.
- FSM, index register and result registers stay in the top.

Test Plan:
1. Behavioural DUT Y=~A&D, defaults, start pulse at cycle 0 → busy 1..49; done at cycle 49; table=16'h00AA; pass=1; mismatch_cnt=0; dut_in steps 0..15, each held 3 cycles.
2. dut_y tied 0, macro undefined → table=16'h0000, mismatch_cnt=4, first_fail_idx=1, pass=0, done at cycle 49. With STOP_ON_FAIL_EN → done at cycle 7, table=0, mismatch_cnt=1, first_fail_idx=1.
3. Correct DUT, extra start pulses at cycles 10 and 49 → ignored; no restart; a single done at cycle 49; results identical to test 1.
4. rst asserted for one cycle at cycle 20 of a sweep → next cycle has all outputs 0 and state IDLE, with no done pulse. A new start then completes with table=16'h00AA.
5. start at cycle 50 (cycle after done) with dut_y tied 1 → results cleared at accept; second done at cycle 99; table=16'hFFFF; mismatch_cnt=12; first_fail_idx=0.
6. SETTLE_CYCLES=1, correct DUT → each vector held 2 cycles; done at cycle 33; pass=1.
